uart_program_buffer: RTL and testbench

//  Parametrised successor to the single-word UART instruction loader. Takes decoded
//  2-bit UART symbols and assembles INSTR_W-bit words MSB-first into a DEPTH-entry program buffer.
//  On the start symbol it hands the buffer to the valve sequencer through a registered read port.

---
 rtl/uart_program_buffer.sv | 167 ++++++++++++++++
 tb/tb_uart_program_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_buffer.sv
// rtl/uart_program_buffer.sv - UART symbol loader into a DEPTH-entry program buffer with registered read port
// Optional LOOP_EN: in RUN the read pointer wraps after the last word and the program repeats.
module uart_program_buffer #(
    parameter int INSTR_W = 13,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_done_tick,
    input  logic [1:0]         rx_sym,
    input  logic               rd_en,
    output logic               run,
    output logic [ADDR_W:0]    instr_count,
    output logic [INSTR_W-1:0] last_instr,
    output logic [INSTR_W-1:0] rd_data,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic               prog_done,
    output logic               overflow,
    output logic               frag_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(INSTR_W + 1);
    localparam logic [1:0] SYM_START = 2'b11;
    localparam logic [1:0] SYM_STOP  = 2'b10;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        RUN  = 2'b01
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;

    logic               is_bit, is_start, is_stop;
    logic [INSTR_W-1:0] shreg_shift;
    logic               word_done, buf_full, last_read, do_write, do_read;

    assign is_bit      = rx_done_tick && !rx_sym[1];
    assign is_start    = rx_done_tick && (rx_sym == SYM_START);
    assign is_stop     = rx_done_tick && (rx_sym == SYM_STOP);
    assign shreg_shift = {shreg[INSTR_W-2:0], rx_sym[0]};
    assign word_done   = is_bit && (bit_cnt == CNT_W'(INSTR_W - 1));
    assign buf_full    = (instr_count == (ADDR_W + 1)'(DEPTH));
    assign last_read   = ({1'b0, rd_ptr} == instr_count - 1'b1);
    assign do_write    = (state == LOAD) && word_done && !buf_full;
    // STOP takes priority over a read request in the same cycle
    assign do_read     = (state == RUN) && !is_stop && rd_en && !prog_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = LOAD;
        case (state)
            LOAD:    state_nxt = is_start ? RUN : LOAD;
            RUN:     state_nxt = is_stop ? LOAD : RUN;
            default: state_nxt = LOAD;
        endcase
    end

    // Buffer contents survive reset and STOP; only the pointers are cleared
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= shreg_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            instr_count <= '0;
            last_instr  <= '0;
            rd_data     <= '0;
            rd_addr     <= '0;
            rd_valid    <= 1'b0;
            prog_done   <= 1'b0;
            overflow    <= 1'b0;
            frag_err    <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                LOAD: begin
                    if (is_bit) begin
                        if (word_done) begin
                            bit_cnt    <= '0;
                            shreg      <= '0;
                            last_instr <= shreg_shift;
                            if (buf_full) begin
                                overflow <= 1'b1;
                            end else begin
                                wr_ptr      <= wr_ptr + 1'b1;
                                instr_count <= instr_count + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg_shift;
                        end
                    end else if (is_start) begin
                        if (bit_cnt != '0) frag_err <= 1'b1;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        run       <= 1'b1;
                        rd_ptr    <= '0;
                        prog_done <= (instr_count == '0);
                    end else if (is_stop) begin
                        if (bit_cnt != '0) frag_err <= 1'b1;
                        bit_cnt     <= '0;
                        shreg       <= '0;
                        wr_ptr      <= '0;
                        instr_count <= '0;
                    end
                end
                RUN: begin
                    if (is_stop) begin
                        run         <= 1'b0;
                        prog_done   <= 1'b0;
                        bit_cnt     <= '0;
                        shreg       <= '0;
                        wr_ptr      <= '0;
                        instr_count <= '0;
                    end else if (do_read) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem[rd_ptr];
                        rd_addr  <= rd_ptr;
                        if (last_read) begin
                            prog_done <= 1'b1;
`ifdef LOOP_EN
                            rd_ptr    <= '0;
`else
                            rd_ptr    <= rd_ptr + 1'b1;
`endif
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
`ifdef LOOP_EN
                    // End-of-pass indication lasts one cycle unless the program is empty
                    else if (instr_count != '0) begin
                        prog_done <= 1'b0;
                    end
`endif
                end
                default: begin
                    run       <= 1'b0;
                    prog_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_buffer.sv
// tb/tb_uart_program_buffer.sv - directed scoreboard bench for uart_program_buffer
module tb_uart_program_buffer;

    localparam int INSTR_W = 13;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam logic [1:0] S_START = 2'b11;
    localparam logic [1:0] S_STOP  = 2'b10;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               rx_done_tick = 1'b0;
    logic [1:0]         rx_sym = 2'b00;
    logic               rd_en = 1'b0;
    logic               run;
    logic [ADDR_W:0]    instr_count;
    logic [INSTR_W-1:0] last_instr;
    logic [INSTR_W-1:0] rd_data;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid;
    logic               prog_done;
    logic               overflow;
    logic               frag_err;

    typedef struct {
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  addr;
        logic               done;
    } rd_exp_t;

    rd_exp_t sb[$];
    int tests = 0;
    int fails = 0;

    uart_program_buffer #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_sym       (rx_sym),
        .rd_en        (rd_en),
        .run          (run),
        .instr_count  (instr_count),
        .last_instr   (last_instr),
        .rd_data      (rd_data),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .prog_done    (prog_done),
        .overflow     (overflow),
        .frag_err     (frag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        rd_exp_t e;
        @(posedge clk);
        #1;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rd_valid", rd_valid, 0);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_addr", rd_addr, e.addr);
                check("prog_done_at_strobe", prog_done, e.done);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_run"}, run, 0);
        check({tag, "_instr_count"}, instr_count, 0);
        check({tag, "_last_instr"}, last_instr, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_prog_done"}, prog_done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_frag_err"}, frag_err, 0);
    endtask

    task automatic send_sym(input logic [1:0] s);
        rx_sym = s;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        rx_sym = 2'b00;
    endtask

    task automatic send_word(input logic [INSTR_W-1:0] w);
        for (int i = INSTR_W - 1; i >= 0; i--) send_sym({1'b0, w[i]});
    endtask

    task automatic read_one(input logic [INSTR_W-1:0] d, input logic [ADDR_W-1:0] a, input logic dn);
        sb.push_back('{data: d, addr: a, done: dn});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic read_ignored;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_idle("reset");

        // reset in the middle of a word
        for (int i = 0; i < 5; i++) send_sym(2'b01);
        rst = 1'b0;
        #1;
        check_idle("async_reset");
        tick();
        rst = 1'b1;
        tick();
        send_word(13'h0A5A);
        check("midreset_count", instr_count, 1);
        check("midreset_last", last_instr, 13'h0A5A);
        send_sym(S_STOP);
        check("stop_flush_count", instr_count, 0);
        check("stop_no_frag", frag_err, 0);

        // three words, then run
        send_word(13'h1ABC);
        send_word(13'h0001);
        send_word(13'h1FFF);
        check("load3_count", instr_count, 3);
        check("load3_last", last_instr, 13'h1FFF);
        read_ignored();
        send_sym(S_START);
        check("start_run", run, 1);
        check("start_done", prog_done, 0);
        read_one(13'h1ABC, 4'd0, 1'b0);
        read_one(13'h0001, 4'd1, 1'b0);
        read_one(13'h1FFF, 4'd2, 1'b1);
`ifdef LOOP_EN
        check("run3_done_pulse_end", prog_done, 0);
`else
        check("run3_done_held", prog_done, 1);
        read_ignored();
`endif
        send_sym(S_STOP);
        check("run_stop_run", run, 0);
        check("run_stop_count", instr_count, 0);

        // STOP with a simultaneous read request
        send_word(13'h0777);
        send_word(13'h1234);
        send_sym(S_START);
        rx_sym = S_STOP;
        rx_done_tick = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        rx_sym = 2'b00;
        rd_en = 1'b0;
        check("stoprd_rd_valid", rd_valid, 0);
        check("stoprd_run", run, 0);
        check("stoprd_count", instr_count, 0);
        check("stoprd_done", prog_done, 0);
        tick();

        // overflow: DEPTH+1 words
        for (int i = 0; i < DEPTH; i++) send_word(INSTR_W'(13'h100 + i));
        check("full_count", instr_count, DEPTH);
        check("full_no_overflow", overflow, 0);
        send_word(13'h110);
        check("ovf_count", instr_count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_last", last_instr, 13'h110);
        send_sym(S_START);
        read_one(13'h100, 4'd0, 1'b0);
        send_sym(S_STOP);
        check("ovf_sticky", overflow, 1);

        // fragment then START on an empty buffer
        for (int i = 0; i < 7; i++) send_sym(2'b01);
        send_sym(S_START);
        check("frag_err", frag_err, 1);
        check("frag_run", run, 1);
        check("frag_done_empty", prog_done, 1);
        check("frag_count", instr_count, 0);
        read_ignored();
        send_sym(S_STOP);
        check("frag_sticky", frag_err, 1);
        check("frag_stop_run", run, 0);

        // two words, repeated reads
        send_word(13'h0123);
        send_word(13'h1F00);
        send_sym(S_START);
`ifdef LOOP_EN
        read_one(13'h0123, 4'd0, 1'b0);
        read_one(13'h1F00, 4'd1, 1'b1);
        check("loop_pulse_clear", prog_done, 0);
        read_one(13'h0123, 4'd0, 1'b0);
        read_one(13'h1F00, 4'd1, 1'b1);
        read_one(13'h0123, 4'd0, 1'b0);
`else
        read_one(13'h0123, 4'd0, 1'b0);
        read_one(13'h1F00, 4'd1, 1'b1);
        for (int i = 0; i < 3; i++) read_ignored();
        check("noloop_done_held", prog_done, 1);
`endif
        send_sym(S_STOP);
        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
